// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared types and constants for the programmable clock generator
package clk_gen_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int MIN_PERIOD = 2;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/clk_gen_cfg_chk.sv
// clk_gen_cfg_chk: combinational legality check of a requested period/high pair
module clk_gen_cfg_chk
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  output logic             ok
);
  assign ok = (period >= CNT_W'(MIN_PERIOD)) && (high != '0) && (high < period);
endmodule

// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl: programmable-duty clock generator with shadowed, boundary-aligned reconfiguration
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_nxt, act_period, act_high, shd_period, shd_high;
  logic pending, has_cfg, cfg_ok, acc, last;
  clk_gen_cfg_chk #(.CNT_W(CNT_W)) u_chk (
    .period(cfg_period),
    .high  (cfg_high),
    .ok    (cfg_ok)
  );
  assign cfg_ready = !pending;
  assign busy = state == RUN;
  assign acc = cfg_valid && cfg_ready;
  assign last = cnt == act_period - 1'b1;
  assign cnt_nxt = cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      clk_out <= 1'b0;
      tick <= 1'b0;
      cfg_err <= 1'b0;
      pending <= 1'b0;
      has_cfg <= 1'b0;
      act_period <= '0;
      act_high <= '0;
      shd_period <= '0;
      shd_high <= '0;
    end else begin
      cfg_err <= acc && !cfg_ok;
      if (state == IDLE) begin
        cnt <= '0;
        clk_out <= 1'b0;
        tick <= 1'b0;
        if (acc && cfg_ok) begin
          act_period <= cfg_period;
          act_high <= cfg_high;
          has_cfg <= 1'b1;
        end
        if (en && has_cfg) begin
          state <= RUN;
          clk_out <= 1'b1;
          tick <= 1'b1;
        end
      end else if (last) begin
        // stopping only here keeps the final period whole, so no runt phase escapes
        cnt <= '0;
        clk_out <= en;
        tick <= en;
        state <= en ? RUN : IDLE;
        if (pending) begin
          act_period <= shd_period;
          act_high <= shd_high;
          pending <= 1'b0;
        end
      end else begin
        cnt <= cnt_nxt;
        clk_out <= cnt_nxt < act_high;
        tick <= 1'b0;
      end
      // acc implies !pending, so this never collides with the boundary clear
      if (state == RUN && acc && cfg_ok) begin
        shd_period <= cfg_period;
        shd_high <= cfg_high;
        pending <= 1'b1;
      end
    end
  end
endmodule
